// File: rtl/uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_rx : 16x oversampled serial receiver, LSB-first, 1 start/1 stop   |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 326,
   parameter int DVSR_W  = 9
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            rx_busy
);
   localparam int S_W = (SB_TICK > 16) ? 5 : 4;
   localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [DVSR_W-1:0] TICK_LAST   = DVSR_W'(DVSR - 1);
   localparam logic [S_W-1:0]    S_MID       = S_W'(7);
   localparam logic [S_W-1:0]    S_BIT_LAST  = S_W'(15);
   localparam logic [S_W-1:0]    S_STOP_LAST = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0]    N_LAST      = N_W'(DBIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   logic              rx_meta, rx_s;
   logic [DVSR_W-1:0] tick_cnt;
   logic              s_tick;
   state_t            state_reg, state_next;
   logic [S_W-1:0]    s_reg, s_next;
   logic [N_W-1:0]    n_reg, n_next;
   logic [DBIT-1:0]   b_reg, b_next;
   logic [DBIT-1:0]   dout_next;
   logic              done_next, ferr_next;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         tick_cnt <= '0;
         s_tick   <= 1'b0;
      end else begin
         rx_meta  <= rx;
         rx_s     <= rx_meta;
         tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + DVSR_W'(1);
         s_tick   <= (tick_cnt == TICK_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         s_reg        <= '0;
         n_reg        <= '0;
         b_reg        <= '0;
         rx_dout      <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         rx_busy      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         s_reg        <= s_next;
         n_reg        <= n_next;
         b_reg        <= b_next;
         rx_dout      <= dout_next;
         rx_done_tick <= done_next;
         frame_err    <= ferr_next;
         rx_busy      <= (state_next != ST_IDLE);
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      dout_next  = rx_dout;
      done_next  = 1'b0;
      ferr_next  = frame_err;
      case (state_reg)
         // Falling-edge detection is ungated so a break re-arms immediately.
         ST_IDLE: begin
            if (!rx_s) begin
               s_next     = '0;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (s_reg == S_MID) begin
                  if (!rx_s) begin
                     s_next     = '0;
                     n_next     = '0;
                     state_next = ST_DATA;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (s_reg == S_BIT_LAST) begin
                  s_next = '0;
                  b_next = {rx_s, b_reg[DBIT-1:1]};
                  if (n_reg == N_LAST) begin
                     state_next = ST_STOP;
                  end else begin
                     n_next = n_reg + N_W'(1);
                  end
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (s_tick) begin
               if (s_reg == S_STOP_LAST) begin
                  done_next  = 1'b1;
                  dout_next  = b_reg;
                  ferr_next  = ~rx_s;
                  state_next = ST_IDLE;
               end else begin
                  s_next = s_reg + S_W'(1);
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_uart_rx : scoreboard bench for uart_rx, DVSR=4 (64 clk per bit)     |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
module tb_uart_rx;
   localparam int BIT_CLK = 64;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_dout;
   logic       rx_done_tick, frame_err, rx_busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic prev_done = 1'b0;
   logic [8:0] exp_q[$];   // {frame_err, data}
   int done_times[$];

   uart_rx #(.DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx           (rx),
      .rx_dout      (rx_dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
      rx = 1'b0;
      hold(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         hold(BIT_CLK);
      end
      rx = stop;
      hold(stop_len);
      rx = 1'b1;
   endtask

   // Monitor: every completion pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (rx_done_tick) begin
         logic [8:0] e;
         done_cnt++;
         done_times.push_back(cyc);
         chk("done_width", {31'd0, prev_done}, 32'd0);
         chk("busy_at_done", {31'd0, rx_busy}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", {24'd0, rx_dout}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("rx_dout", {24'd0, rx_dout}, {24'd0, e[7:0]});
            chk("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
         end
      end
      prev_done = rx_done_tick;
   end

   initial begin
      int gap;
      // Reset held while the line toggles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_dout", {24'd0, rx_dout}, 32'd0);
         chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
         chk("rst_ferr", {31'd0, frame_err}, 32'd0);
         chk("rst_busy", {31'd0, rx_busy}, 32'd0);
         @(posedge clk); #1;
         rx = ~rx;
      end
      rx = 1'b1;
      reset_n = 1'b1;
      hold(100);

      // Valid frame
      exp_q.push_back({1'b0, 8'hA5});
      send_frame(8'hA5, 1'b1, BIT_CLK);
      hold(200);
      chk("valid_busy_low", {31'd0, rx_busy}, 32'd0);
      chk("valid_done_cnt", done_cnt, 1);

      // Glitch shorter than half a bit
      rx = 1'b0;
      hold(10);
      @(negedge clk);
      chk("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
      hold(10);
      rx = 1'b1;
      hold(1000);
      chk("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
      chk("glitch_done_cnt", done_cnt, 1);
      chk("glitch_dout_kept", {24'd0, rx_dout}, 32'hA5);

      // Framing error, then a good frame
      exp_q.push_back({1'b1, 8'h3C});
      send_frame(8'h3C, 1'b0, 44);
      hold(200);
      exp_q.push_back({1'b0, 8'h00});
      send_frame(8'h00, 1'b1, BIT_CLK);
      hold(200);
      chk("ferr_done_cnt", done_cnt, 3);

      // Back-to-back frames with no idle gap
      exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b0, 8'hFF});
      send_frame(8'h55, 1'b1, BIT_CLK);
      send_frame(8'hFF, 1'b1, BIT_CLK);
      hold(200);
      chk("b2b_done_cnt", done_cnt, 5);
      if (done_times.size() >= 5) begin
         gap = done_times[4] - done_times[3];
         chk("b2b_gap_in_range", {31'd0, (gap >= 632 && gap <= 648)}, 32'd1);
      end else begin
         chk("b2b_gap_samples", done_times.size(), 5);
      end

      // Reset during data bit 3 of 0x12
      rx = 1'b0;
      hold(BIT_CLK);
      for (int i = 0; i < 3; i++) begin
         rx = ((8'h12 >> i) & 8'h01) != 0;
         hold(BIT_CLK);
      end
      rx = 1'b0;
      hold(BIT_CLK / 2);
      reset_n = 1'b0;
      rx = 1'b1;
      hold(1);
      reset_n = 1'b1;
      @(negedge clk);
      chk("abort_dout", {24'd0, rx_dout}, 32'd0);
      chk("abort_ferr", {31'd0, frame_err}, 32'd0);
      chk("abort_busy", {31'd0, rx_busy}, 32'd0);
      hold(1000);
      chk("abort_no_done", done_cnt, 5);
      exp_q.push_back({1'b0, 8'h81});
      send_frame(8'h81, 1'b1, BIT_CLK);
      hold(200);
      chk("after_abort_done_cnt", done_cnt, 6);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
